// File: rtl/rambus_dma.sv
// Wishbone classic DMA initiator for the 32-bit RAM target: runs one
// word-granular FILL, COPY or SUM command at a time, with an ack timeout.
module rambus_dma #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        rambus_wb_clk_i,
  input  logic        rambus_wb_rst_ni,
  input  logic        cmd_start_i,
  input  logic [1:0]  cmd_mode_i,
  input  logic [8:0]  cmd_src_i,
  input  logic [8:0]  cmd_dst_i,
  input  logic [7:0]  cmd_len_i,
  input  logic [31:0] cmd_fill_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] result_o,
  output logic        rambus_wb_cyc_o,
  output logic        rambus_wb_stb_o,
  output logic        rambus_wb_we_o,
  output logic [3:0]  rambus_wb_sel_o,
  output logic [8:0]  rambus_wb_addr_o,
  output logic [31:0] rambus_wb_dat_o,
  input  logic        rambus_wb_ack_i,
  input  logic [31:0] rambus_wb_dat_i
);

  typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

  localparam logic [1:0] ModeFill = 2'b00;
  localparam logic [1:0] ModeCopy = 2'b01;
  localparam logic [1:0] ModeRsvd = 2'b11;
  // Abort on the edge where the no-ack count would reach TIMEOUT.
  localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [8:0]  src_q, src_d;
  logic [8:0]  dst_q, dst_d;
  logic [7:0]  len_q, len_d;
  logic [31:0] fill_q, fill_d;
  logic [7:0]  idx_q, idx_d;
  logic        wr_phase_q, wr_phase_d;  // COPY: 0 = read half, 1 = write half
  logic [31:0] data_q, data_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        access_we;
  logic [8:0]  access_addr;
  logic [8:0]  word_off;
  logic        in_req;
  logic        unused_addr_lsbs;

  // Low address bits are forced to zero on accept, so the inputs' [1:0] are dropped.
  assign unused_addr_lsbs = ^{cmd_src_i[1:0], cmd_dst_i[1:0]};

  // Current access decode: direction and word address (wraps modulo 512).
  always_comb begin
    access_we   = (mode_q == ModeFill) || ((mode_q == ModeCopy) && wr_phase_q);
    word_off    = {idx_q[6:0], 2'b00};
    access_addr = (access_we ? dst_q : src_q) + word_off;
  end

  // Next-state logic for the command sequencer.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    fill_d     = fill_q;
    idx_d      = idx_q;
    wr_phase_d = wr_phase_q;
    data_d     = data_q;
    result_d   = result_q;
    err_d      = err_q;
    tmo_d      = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_start_i) begin
          mode_d     = cmd_mode_i;
          src_d      = {cmd_src_i[8:2], 2'b00};
          dst_d      = {cmd_dst_i[8:2], 2'b00};
          len_d      = cmd_len_i;
          fill_d     = cmd_fill_i;
          idx_d      = 8'd0;
          wr_phase_d = 1'b0;
          result_d   = 32'd0;
          err_d      = (cmd_mode_i == ModeRsvd);
          tmo_d      = 8'd0;
          if ((cmd_len_i == 8'd0) || (cmd_mode_i == ModeRsvd)) begin
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (rambus_wb_ack_i) begin
          if (!access_we) begin
            data_d   = rambus_wb_dat_i;
            result_d = result_q + rambus_wb_dat_i;
          end
          // A COPY read is followed by its write at the same index.
          if ((mode_q == ModeCopy) && !wr_phase_q) begin
            wr_phase_d = 1'b1;
          end else begin
            wr_phase_d = 1'b0;
            idx_d      = idx_q + 8'd1;
          end
          state_d = StGap;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StGap: begin
        // The target's trailing ack lands here and is deliberately ignored.
        tmo_d   = 8'd0;
        state_d = (idx_q == len_q) ? StDone : StReq;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge rambus_wb_clk_i or negedge rambus_wb_rst_ni) begin
    if (!rambus_wb_rst_ni) begin
      state_q    <= StIdle;
      mode_q     <= 2'b00;
      src_q      <= 9'd0;
      dst_q      <= 9'd0;
      len_q      <= 8'd0;
      fill_q     <= 32'd0;
      idx_q      <= 8'd0;
      wr_phase_q <= 1'b0;
      data_q     <= 32'd0;
      result_q   <= 32'd0;
      err_q      <= 1'b0;
      tmo_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      idx_q      <= idx_d;
      wr_phase_q <= wr_phase_d;
      data_q     <= data_d;
      result_q   <= result_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  // Outputs decode from registers only; bus fields are zero outside REQ.
  always_comb begin
    in_req           = (state_q == StReq);
    rambus_wb_cyc_o  = in_req;
    rambus_wb_stb_o  = in_req;
    rambus_wb_sel_o  = in_req ? 4'hF : 4'h0;
    rambus_wb_we_o   = in_req && access_we;
    rambus_wb_addr_o = in_req ? access_addr : 9'd0;
    rambus_wb_dat_o  = 32'd0;
    if (in_req && access_we) begin
      rambus_wb_dat_o = (mode_q == ModeFill) ? fill_q : data_q;
    end
    busy_o   = in_req || (state_q == StGap);
    done_o   = (state_q == StDone);
    err_o    = err_q;
    result_o = result_q;
  end

endmodule

// File: tb/tb_rambus_dma.sv
// Self-checking bench for rambus_dma: RAM target model with 1-cycle ack plus a
// command-level reference model (expected memory image, access list, sum, latency).
module tb_rambus_dma;

  typedef struct packed {
    logic        we;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start;
  logic [1:0]  cmd_mode;
  logic [8:0]  cmd_src;
  logic [8:0]  cmd_dst;
  logic [7:0]  cmd_len;
  logic [31:0] cmd_fill;
  logic        busy, done, err;
  logic [31:0] result;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [8:0]  addr;
  logic [31:0] dat_w;
  logic        ack_q;
  logic [31:0] rd_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rambus_dma #(.TIMEOUT(255)) u_dut (
    .rambus_wb_clk_i  (clk),
    .rambus_wb_rst_ni (rst_n),
    .cmd_start_i      (cmd_start),
    .cmd_mode_i       (cmd_mode),
    .cmd_src_i        (cmd_src),
    .cmd_dst_i        (cmd_dst),
    .cmd_len_i        (cmd_len),
    .cmd_fill_i       (cmd_fill),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err),
    .result_o         (result),
    .rambus_wb_cyc_o  (cyc),
    .rambus_wb_stb_o  (stb),
    .rambus_wb_we_o   (we),
    .rambus_wb_sel_o  (sel),
    .rambus_wb_addr_o (addr),
    .rambus_wb_dat_o  (dat_w),
    .rambus_wb_ack_i  (ack_q),
    .rambus_wb_dat_i  (rd_q)
  );

  // RAM target model: 128 words, ack one cycle after stb, ack lingers one cycle.
  logic [31:0] mem [128];
  logic        ack_en;
  logic        scramble;
  logic        pl_en;
  logic [6:0]  pl_idx;
  logic [31:0] pl_val;
  acc_t        obs_q[$];

  always @(posedge clk) begin
    ack_q <= ack_en & cyc & stb;
    if (scramble) begin
      for (int i = 0; i < 128; i++) mem[i] <= $urandom;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (ack_en && cyc && stb && !ack_q) begin
      obs_q.push_back({we, addr, (we ? dat_w : mem[addr[8:2]]), sel});
      if (we) mem[addr[8:2]] <= dat_w;
      rd_q <= mem[addr[8:2]];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = 7'(idx);
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic scramble_mem();
    scramble = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
  endtask

  // Issue one command (at a negedge, DUT idle) and compare against the model.
  task automatic run_cmd(input string name, input logic [1:0] mode, input logic [8:0] src,
                         input logic [8:0] dst, input logic [7:0] len,
                         input logic [31:0] fill, input bit poke);
    logic [31:0] ref_mem [128];
    acc_t        exp_q[$];
    logic [31:0] exp_res;
    logic [31:0] w;
    int          exp_lat, lat, stb_cnt, nmis, sa, da, n;

    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
    exp_res = 32'd0;
    if (mode != 2'b11) begin
      for (int i = 0; i < int'(len); i++) begin
        sa = (int'(src & 9'h1FC) + 4 * i) % 512;
        da = (int'(dst & 9'h1FC) + 4 * i) % 512;
        case (mode)
          2'b00: begin
            ref_mem[da / 4] = fill;
            exp_q.push_back({1'b1, 9'(da), fill, 4'hF});
          end
          2'b01: begin
            w = ref_mem[sa / 4];
            exp_q.push_back({1'b0, 9'(sa), w, 4'hF});
            exp_res += w;
            ref_mem[da / 4] = w;
            exp_q.push_back({1'b1, 9'(da), w, 4'hF});
          end
          default: begin
            w = ref_mem[sa / 4];
            exp_q.push_back({1'b0, 9'(sa), w, 4'hF});
            exp_res += w;
          end
        endcase
      end
    end
    if (len == 8'd0 || mode == 2'b11) exp_lat = 1;
    else if (mode == 2'b01)           exp_lat = 6 * int'(len) + 1;
    else                              exp_lat = 3 * int'(len) + 1;

    obs_q.delete();
    cmd_mode  = mode;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_fill  = fill;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    lat     = 1;
    stb_cnt = 0;
    while (!done && lat < 3000) begin
      if (stb) stb_cnt++;
      if (poke && lat == 4) begin
        cmd_start = 1'b1;
        cmd_mode  = 2'b11;
        cmd_len   = 8'hFF;
        cmd_fill  = ~fill;
        cmd_dst   = ~dst;
      end else begin
        cmd_start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    cmd_start = 1'b0;
    check_eq({name, ".latency"}, 64'(lat), 64'(exp_lat));
    check_eq({name, ".err"}, 64'(err), 64'(mode == 2'b11));
    check_eq({name, ".result"}, 64'(result), 64'(exp_res));
    check_eq({name, ".busy_in_done"}, 64'(busy), 64'd0);
    check_eq({name, ".stb_cycles"}, 64'(stb_cnt), 64'(2 * exp_q.size()));
    @(negedge clk);
    check_eq({name, ".done_one_cycle"}, 64'(done), 64'd0);
    nmis = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) nmis++;
    check_eq({name, ".mem_mismatches"}, 64'(nmis), 64'd0);
    check_eq({name, ".n_access"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({name, ".access"}, 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int lat, stb_cnt;
    rst_n     = 1'b0;
    cmd_start = 1'b0;
    cmd_mode  = 2'b00;
    cmd_src   = 9'd0;
    cmd_dst   = 9'd0;
    cmd_len   = 8'd0;
    cmd_fill  = 32'd0;
    ack_en    = 1'b1;
    scramble  = 1'b0;
    pl_en     = 1'b0;
    pl_idx    = 7'd0;
    pl_val    = 32'd0;
    #1;
    check_eq("reset.outputs",
             64'({busy, done, err, result, cyc, stb, we, sel, addr}), 64'd0);
    check_eq("reset.dat_o", 64'(dat_w), 64'd0);
    scramble_mem();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FILL example: words 4..7, 13-cycle latency, result stays 0.
    run_cmd("fill", 2'b00, 9'h000, 9'h010, 8'd4, 32'hA5A5_1234, 1'b0);
    check_eq("fill.word7", 64'(mem[7]), 64'hA5A5_1234);

    // COPY with wrapping sum 1 + 2 + 0xFFFFFFFF = 2.
    set_word(0, 32'd1);
    set_word(1, 32'd2);
    set_word(2, 32'hFFFF_FFFF);
    run_cmd("copy", 2'b01, 9'h000, 9'h100, 8'd3, 32'd0, 1'b0);
    check_eq("copy.result_const", 64'(result), 64'h2);
    check_eq("copy.word66", 64'(mem[66]), 64'hFFFF_FFFF);

    // SUM across the 0x1FC -> 0x000 wrap.
    set_word(127, 32'd5);
    set_word(0, 32'd7);
    run_cmd("sum_wrap", 2'b10, 9'h1FC, 9'h000, 8'd2, 32'd0, 1'b0);
    check_eq("sum_wrap.result_const", 64'(result), 64'd12);

    // Immediate completions (src/dst low bits set to exercise masking elsewhere).
    run_cmd("len0", 2'b00, 9'h003, 9'h013, 8'd0, 32'hDEAD_BEEF, 1'b0);
    run_cmd("rsvd", 2'b11, 9'h000, 9'h040, 8'd5, 32'h1, 1'b0);

    // Start pulsed mid-FILL must be ignored: exactly 8 writes.
    run_cmd("fill_poke", 2'b00, 9'h000, 9'h0F3, 8'd8, 32'h0BAD_F00D, 1'b1);

    // Timeout: no ack, SUM len=1.
    ack_en    = 1'b0;
    cmd_mode  = 2'b10;
    cmd_src   = 9'h080;
    cmd_len   = 8'd1;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    lat     = 1;
    stb_cnt = 0;
    while (!done && lat < 1000) begin
      if (stb) stb_cnt++;
      @(negedge clk);
      lat++;
    end
    check_eq("tmo.latency", 64'(lat), 64'd256);
    check_eq("tmo.stb_cycles", 64'(stb_cnt), 64'd255);
    check_eq("tmo.err", 64'(err), 64'd1);
    check_eq("tmo.result", 64'(result), 64'd0);
    @(negedge clk);
    check_eq("tmo.done_one_cycle", 64'(done), 64'd0);
    check_eq("tmo.err_held", 64'(err), 64'd1);
    ack_en = 1'b1;

    // Reset in the middle of a COPY, then a fresh FILL.
    set_word(0, 32'h1111_0001);
    set_word(1, 32'h2222_0002);
    cmd_mode  = 2'b01;
    cmd_src   = 9'h000;
    cmd_dst   = 9'h100;
    cmd_len   = 8'd4;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("rst_mid.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid.outputs", 64'({cyc, stb, busy, done, err}), 64'd0);
    check_eq("rst_mid.result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd("fill_after_rst", 2'b00, 9'h000, 9'h020, 8'd5, 32'h5A5A_C3C3, 1'b0);

    // Randomized commands against the reference model.
    for (int k = 0; k < 20; k++) begin
      scramble_mem();
      run_cmd("rand", 2'($urandom_range(0, 3)), 9'($urandom), 9'($urandom),
              8'($urandom_range(0, 12)), $urandom, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
